// File: rtl/dmem_responder.sv
// Wait-state data memory responder: takes one load/store over a valid/ready handshake,
// holds it for WAIT_CYCLES, then accesses word storage and returns data/err on a response handshake.

module dmem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [7:0]  old_byte,
  output logic [7:0]  new_byte
);
  localparam logic [1:0] K = 2'(LANE);

  logic       we;
  logic [1:0] sel;

  // Store data is right-justified, so each lane picks its source byte by offset within the access.
  always_comb begin
    we  = 1'b0;
    sel = 2'd0;
    case (size)
      2'b00: begin we = 1'b1;                 sel = K;              end
      2'b01: begin we = (addr_lo[1] == K[1]); sel = {1'b0, K[0]};   end
      2'b10: begin we = (addr_lo == K);       sel = 2'd0;           end
      default: begin we = 1'b0;               sel = 2'd0;           end
    endcase
    new_byte = we ? wdata[8*sel +: 8] : old_byte;
  end
endmodule

module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int          NUM_LANES = 4;
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } dmem_req_t;

  state_t    state, state_nxt;
  logic [3:0] wait_cnt;
  dmem_req_t req_in, req_q, acc;
  logic      accept, do_access, acc_err;
  logic [31:0] off, rd_word, rd_shift, ld_data;
  logic [AW-1:0] idx;
  logic [NUM_LANES-1:0][7:0] rd_lanes, wr_lanes;
  logic [31:0] mem [DEPTH_WORDS];

  assign req_in = {req_write, req_addr, req_size, req_unsigned, req_wdata};
  assign accept = (state == S_IDLE) && req_valid;
  // With zero wait states the access happens on the accept edge, straight from the inputs.
  assign acc    = (state == S_IDLE) ? req_in : req_q;
  assign do_access = rst_n &&
                     ((accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (wait_cnt == 4'd1)));

  assign off     = acc.addr - BASE_ADDR;
  assign idx     = off[AW+1:2];
  assign acc_err = ({1'b0, off} >= SPAN) || (acc.size == 2'b11) ||
                   ((acc.size == 2'b01) && acc.addr[0]) ||
                   ((acc.size == 2'b00) && (acc.addr[1:0] != 2'b00));

  assign rd_word  = mem[idx];
  assign rd_lanes = rd_word;
  assign rd_shift = rd_word >> {acc.addr[1:0], 3'b000};

  always_comb begin
    case (acc.size)
      2'b10:   ld_data = acc.uns ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   ld_data = acc.uns ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    dmem_lane #(.LANE(k)) u_lane (
      .size     (acc.size),
      .addr_lo  (acc.addr[1:0]),
      .wdata    (acc.wdata),
      .old_byte (rd_lanes[k]),
      .new_byte (wr_lanes[k])
    );
  end

  always_ff @(posedge clk) begin
    if (do_access && acc.write && !acc_err)
      mem[idx] <= wr_lanes;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_cnt == 4'd1) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 4'd0;
      req_q     <= '0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt <= WAIT_INIT;
        req_q    <= req_in;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (do_access) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc.write) ? 32'd0 : ld_data;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two builds (2 wait states / 1K words at 0, 0 wait states / 16 words at 0x1000)
// checked every cycle against a byte-array transaction model plus directed literal expectations.

module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_write, req_unsigned, rsp_ready;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][1:0]  req_size;
  logic rr0, rr1, rv0, rv1, re0, re1;
  logic [31:0] rd0, rd1;
  logic [1:0]       req_ready, rsp_valid, rsp_err;
  logic [1:0][31:0] rsp_rdata;
  assign req_ready = {rr1, rr0};
  assign rsp_valid = {rv1, rv0};
  assign rsp_err   = {re1, re0};
  assign rsp_rdata = {rd1, rd0};

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(rr0), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rv0), .rsp_ready(rsp_ready[0]), .rsp_rdata(rd0), .rsp_err(re0));

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(rr1), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rv1), .rsp_ready(rsp_ready[1]), .rsp_rdata(rd1), .rsp_err(re1));

  int checks = 0;
  int fails  = 0;

  task automatic chk(string nm, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, id, act, exp, $time);
    end
  endtask

  function automatic int wcfg(int id);      return (id == 0) ? 2 : 0;            endfunction
  function automatic logic [31:0] span(int id); return (id == 0) ? 32'd4096 : 32'd64; endfunction
  function automatic logic [31:0] base(int id); return (id == 0) ? 32'h0 : 32'h1000;  endfunction

  // Transaction model: byte-addressed storage, one outstanding request per build.
  bit [7:0]    mb [2][4096];
  bit          busy [2];
  bit          done [2];
  int          acc_cyc [2];
  int          cyc = 0;
  bit          m_wr [2];
  bit          m_un [2];
  logic [1:0]  m_sz [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd [2];
  logic [31:0] exp_rd [2];
  bit          exp_er [2];

  task automatic model_access(int id);
    logic [31:0] off, v;
    int n;
    bit err;
    off = m_addr[id] - base(id);
    n = (m_sz[id] == 2'b00) ? 4 : (m_sz[id] == 2'b01) ? 2 : 1;
    err = (off >= span(id)) || (m_sz[id] == 2'b11) ||
          (n == 2 && m_addr[id][0]) || (n == 4 && m_addr[id][1:0] != 2'b00);
    exp_er[id] = err;
    exp_rd[id] = 32'd0;
    if (!err) begin
      if (m_wr[id]) begin
        for (int i = 0; i < n; i++) mb[id][off + i] = m_wd[id][8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[id][off + i]) << (8*i));
        if (!m_un[id] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        exp_rd[id] = v;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int id = 0; id < 2; id++) begin busy[id] = 0; done[id] = 0; end
    end else begin
      cyc++;
      for (int id = 0; id < 2; id++) begin
        if (busy[id]) begin
          if (done[id] && rsp_ready[id]) busy[id] = 0;
        end else if (req_valid[id]) begin
          busy[id] = 1; done[id] = 0; acc_cyc[id] = cyc;
          m_wr[id] = req_write[id]; m_addr[id] = req_addr[id]; m_sz[id] = req_size[id];
          m_un[id] = req_unsigned[id]; m_wd[id] = req_wdata[id];
        end
        if (busy[id] && !done[id] && cyc == acc_cyc[id] + wcfg(id)) begin
          model_access(id);
          done[id] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      chk("cyc_req_ready", id, req_ready[id], !busy[id]);
      chk("cyc_rsp_valid", id, rsp_valid[id], busy[id] && done[id]);
      if (busy[id] && done[id]) begin
        chk("cyc_rsp_rdata", id, rsp_rdata[id], exp_rd[id]);
        chk("cyc_rsp_err", id, rsp_err[id], exp_er[id]);
      end
    end
  end

  task automatic start_req(int id, bit wr, logic [31:0] a, logic [1:0] sz, bit un, logic [31:0] wd);
    req_write[id] = wr; req_addr[id] = a; req_size[id] = sz; req_unsigned[id] = un;
    req_wdata[id] = wd; req_valid[id] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        return;
      end
    end
    chk("accept_timeout", id, 32'd0, 32'd1);
    req_valid[id] = 1'b0;
  endtask

  task automatic finish_rsp(int id, output logic [31:0] rd, output logic er, output int lat);
    rsp_ready[id] = 1'b0;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (rsp_valid[id]) break;
    end
    rd = rsp_rdata[id];
    er = rsp_err[id];
    rsp_ready[id] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[id] = 1'b0;
  endtask

  task automatic xact(string nm, int id, bit wr, logic [31:0] a, logic [1:0] sz, bit un,
                      logic [31:0] wd, logic [31:0] x_rd, bit x_er);
    logic [31:0] rd;
    logic er;
    int lat;
    start_req(id, wr, a, sz, un, wd);
    finish_rsp(id, rd, er, lat);
    chk({nm, "_rdata"}, id, rd, x_rd);
    chk({nm, "_err"}, id, er, x_er);
    chk({nm, "_latency"}, id, lat, wcfg(id) + 1);
  endtask

  logic [31:0] b2b_addr [4] = '{32'h1000, 32'h1006, 32'h103F, 32'h1004};
  logic [1:0]  b2b_sz   [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
  bit          b2b_un   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] b2b_exp  [4] = '{32'h0123_4567, 32'hFFFF_8001, 32'h0000_0089, 32'h8001_0000};

  initial begin
    time t, t_prev;
    req_valid = '0; req_write = '0; req_unsigned = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_size = '0;
    #12;
    for (int id = 0; id < 2; id++) begin
      chk("rst_req_ready", id, req_ready[id], 1);
      chk("rst_rsp_valid", id, rsp_valid[id], 0);
      chk("rst_rsp_rdata", id, rsp_rdata[id], 0);
      chk("rst_rsp_err", id, rsp_err[id], 0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    xact("st_word",     0, 1, 32'h10, 2'b00, 0, 32'hDEAD_BEEF, 32'h0, 0);
    xact("ld_word",     0, 0, 32'h10, 2'b00, 0, 32'h0,         32'hDEAD_BEEF, 0);
    xact("st_word20",   0, 1, 32'h20, 2'b00, 0, 32'h1122_3344, 32'h0, 0);
    xact("st_byte21",   0, 1, 32'h21, 2'b10, 0, 32'hABCD_EF80, 32'h0, 0);
    xact("ld_sbyte",    0, 0, 32'h21, 2'b10, 0, 32'h0, 32'hFFFF_FF80, 0);
    xact("ld_ubyte",    0, 0, 32'h21, 2'b10, 1, 32'h0, 32'h0000_0080, 0);
    xact("ld_uhalf",    0, 0, 32'h22, 2'b01, 1, 32'h0, 32'h0000_1122, 0);
    xact("ld_shalf",    0, 0, 32'h20, 2'b01, 0, 32'h0, 32'hFFFF_8044, 0);
    xact("ld_merged",   0, 0, 32'h20, 2'b00, 0, 32'h0, 32'h1122_8044, 0);
    xact("ld_misalign", 0, 0, 32'h22, 2'b00, 0, 32'h0, 32'h0, 1);
    xact("st_misalign", 0, 1, 32'h21, 2'b01, 0, 32'h0000_5555, 32'h0, 1);
    xact("ld_unchanged",0, 0, 32'h20, 2'b00, 0, 32'h0, 32'h1122_8044, 0);
    xact("ld_oor",      0, 0, 32'h1000, 2'b00, 0, 32'h0, 32'h0, 1);
    xact("st_oor",      0, 1, 32'h1000, 2'b10, 0, 32'h0000_00AA, 32'h0, 1);
    xact("ld_size11",   0, 0, 32'h20, 2'b11, 0, 32'h0, 32'h0, 1);

    // Response backpressure with a competing request already presented.
    start_req(0, 0, 32'h20, 2'b00, 0, 32'h0);
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rsp_valid[0]) break; end
    req_write[0] = 1'b0; req_addr[0] = 32'h10; req_size[0] = 2'b00; req_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 0, rsp_valid[0], 1);
      chk("bp_rdata", 0, rsp_rdata[0], 32'h1122_8044);
      chk("bp_ready", 0, req_ready[0], 0);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1; rsp_ready[0] = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", 0, rsp_valid[0], 0);
    chk("bp_after_ready", 0, req_ready[0], 1);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    begin
      logic [31:0] rd; logic er; int lat;
      finish_rsp(0, rd, er, lat);
      chk("bp_next_rdata", 0, rd, 32'hDEAD_BEEF);
      chk("bp_next_latency", 0, lat, 3);
    end

    // Reset while a store waits: the store is dropped.
    xact("st_zero30", 0, 1, 32'h30, 2'b00, 0, 32'h0, 32'h0, 0);
    xact("ld_pre_rst", 0, 0, 32'h10, 2'b00, 0, 32'h0, 32'hDEAD_BEEF, 0);
    start_req(0, 1, 32'h30, 2'b00, 0, 32'hCAFE_BABE);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("mid_rst_ready", 0, req_ready[0], 1);
    chk("mid_rst_valid", 0, rsp_valid[0], 0);
    chk("mid_rst_rdata", 0, rsp_rdata[0], 0);
    chk("mid_rst_err", 0, rsp_err[0], 0);
    @(negedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    xact("ld_dropped", 0, 0, 32'h30, 2'b00, 0, 32'h0, 32'h0, 0);

    // Reset while the response is pending: the committed store survives.
    start_req(0, 1, 32'h34, 2'b00, 0, 32'h55AA_55AA);
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rsp_valid[0]) break; end
    #2; rst_n = 1'b0; #1;
    chk("resp_rst_valid", 0, rsp_valid[0], 0);
    @(negedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    xact("ld_committed", 0, 0, 32'h34, 2'b00, 0, 32'h0, 32'h55AA_55AA, 0);

    // Zero-wait build at a nonzero base.
    xact("z_st0",    1, 1, 32'h1000, 2'b00, 0, 32'h0123_4567, 32'h0, 0);
    xact("z_st4",    1, 1, 32'h1004, 2'b00, 0, 32'h0,         32'h0, 0);
    xact("z_sth6",   1, 1, 32'h1006, 2'b01, 0, 32'hFFFF_8001, 32'h0, 0);
    xact("z_st3c",   1, 1, 32'h103C, 2'b00, 0, 32'h89AB_CDEF, 32'h0, 0);
    xact("z_oor_hi", 1, 0, 32'h1040, 2'b00, 0, 32'h0, 32'h0, 1);
    xact("z_oor_lo", 1, 0, 32'h0FFC, 2'b00, 0, 32'h0, 32'h0, 1);
    xact("z_st_oor", 1, 1, 32'h1040, 2'b10, 0, 32'h0000_0011, 32'h0, 1);

    rsp_ready[1] = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      req_write[1] = 1'b0; req_addr[1] = b2b_addr[k]; req_size[1] = b2b_sz[k];
      req_unsigned[1] = b2b_un[k]; req_valid[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (req_ready[1]) break; end
      @(posedge clk); t = $time; #1;
      if (k > 0) chk("b2b_gap", 1, 32'(t - t_prev), 32'd20);
      t_prev = t;
      @(negedge clk);
      chk("b2b_valid", 1, rsp_valid[1], 1);
      chk("b2b_rdata", 1, rsp_rdata[1], b2b_exp[k]);
    end
    req_valid[1] = 1'b0;
    @(posedge clk); #1; rsp_ready[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end
endmodule
